// File: rtl/poly_voice_controller.sv
// Polyphonic voice controller: allocates note-on/note-off events across a bank of
// square-wave oscillators (lowest free voice first, oldest voice stolen when full)
// and mixes the voices into one registered two's-complement sample.
module poly_voice_controller #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned AMP_W      = 16,
    parameter int unsigned KEY_W      = 7,
    // Derived: holds +/- NUM_VOICES * (2^AMP_W - 1) without overflow
    parameter int unsigned OUT_W      = AMP_W + 1 + $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [KEY_W-1:0]      ev_key,
    input  logic [PERIOD_W-1:0]   ev_half_period,
    input  logic [AMP_W-1:0]      amplitude,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  voice_stolen,
    output logic [OUT_W-1:0]      wave_out
);

    localparam int unsigned      IDX_W      = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] OLDEST_AGE = IDX_W'(NUM_VOICES - 1);

    // Event captured at accept, processed on the following edge
    logic                pend_q;
    logic                pend_on_q;
    logic [KEY_W-1:0]    pend_key_q;
    logic [PERIOD_W-1:0] pend_hp_q;
    logic                accept;

    // Per-voice state
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [NUM_VOICES-1:0] phase_q, phase_d;
    logic [KEY_W-1:0]      key_q [NUM_VOICES];
    logic [KEY_W-1:0]      key_d [NUM_VOICES];
    logic [PERIOD_W-1:0]   hp_q  [NUM_VOICES];
    logic [PERIOD_W-1:0]   hp_d  [NUM_VOICES];
    logic [PERIOD_W-1:0]   cnt_q [NUM_VOICES];
    logic [PERIOD_W-1:0]   cnt_d [NUM_VOICES];
    // Age 0 is the newest active voice; active voices hold unique ages
    logic [IDX_W-1:0]      age_q [NUM_VOICES];
    logic [IDX_W-1:0]      age_d [NUM_VOICES];

    logic             stolen_q, stolen_d;
    logic [OUT_W-1:0] wave_q, wave_d;

    // Lookup results for the pending event
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] oldest_idx;

    // Event decode
    logic                do_on;
    logic                do_off;
    logic                bump_all;
    logic [IDX_W-1:0]    tgt_idx;
    logic [IDX_W-1:0]    tgt_age;
    logic [PERIOD_W-1:0] ev_hp;

    // One event in flight at a time gives one accept per two cycles
    assign ev_ready = ~pend_q;
    assign accept   = ev_valid & ~pend_q;

    // Capture the event fields on accept and hold them for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q     <= 1'b0;
            pend_on_q  <= 1'b0;
            pend_key_q <= '0;
            pend_hp_q  <= '0;
        end else if (accept) begin
            pend_q     <= 1'b1;
            pend_on_q  <= ev_on;
            pend_key_q <= ev_key;
            pend_hp_q  <= ev_half_period;
        end else begin
            pend_q     <= 1'b0;
        end
    end

    // Find matching key, lowest free voice and oldest active voice
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        oldest_idx = '0;
        // Descending scan so the lowest index wins
        for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
            if (active_q[i] && (key_q[i] == pend_key_q)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!active_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (active_q[i] && (age_q[i] == OLDEST_AGE)) begin
                oldest_idx = IDX_W'(i);
            end
        end
    end

    // Oscillator stepping plus allocation/release of the pending event
    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        ev_hp    = (pend_hp_q == '0) ? PERIOD_W'(1) : pend_hp_q;

        // Retrigger only ages the voices newer than the retriggered one
        if (match_hit) begin
            tgt_idx  = match_idx;
            bump_all = 1'b0;
        end else if (free_hit) begin
            tgt_idx  = free_idx;
            bump_all = 1'b1;
        end else begin
            tgt_idx  = oldest_idx;
            bump_all = 1'b1;
        end
        tgt_age  = age_q[tgt_idx];

        do_on    = pend_q & pend_on_q;
        do_off   = pend_q & ~pend_on_q & match_hit;
        stolen_d = do_on & ~match_hit & ~free_hit;

        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            key_d[i] = key_q[i];
            hp_d[i]  = hp_q[i];
            age_d[i] = age_q[i];

            if (!active_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == hp_q[i] - PERIOD_W'(1)) begin
                cnt_d[i]   = '0;
                phase_d[i] = ~phase_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
            end

            if (do_on) begin
                if (IDX_W'(i) == tgt_idx) begin
                    active_d[i] = 1'b1;
                    phase_d[i]  = 1'b1;
                    cnt_d[i]    = '0;
                    key_d[i]    = pend_key_q;
                    hp_d[i]     = ev_hp;
                    age_d[i]    = '0;
                end else if (active_q[i] && (bump_all || (age_q[i] < tgt_age))) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end else if (do_off) begin
                if (IDX_W'(i) == tgt_idx) begin
                    active_d[i] = 1'b0;
                    phase_d[i]  = 1'b0;
                    cnt_d[i]    = '0;
                    age_d[i]    = '0;
                end else if (active_q[i] && (age_q[i] > tgt_age)) begin
                    // Close the gap left by the released voice
                    age_d[i] = age_q[i] - IDX_W'(1);
                end
            end
        end
    end

    // Voice state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= '0;
            phase_q  <= '0;
            stolen_q <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                key_q[i] <= '0;
                hp_q[i]  <= '0;
                cnt_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            stolen_q <= stolen_d;
            key_q    <= key_d;
            hp_q     <= hp_d;
            cnt_q    <= cnt_d;
            age_q    <= age_d;
        end
    end

    // Sum of +/-amplitude per active voice; modular add is exact at this width
    always_comb begin
        wave_d = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (active_q[i]) begin
                if (phase_q[i]) begin
                    wave_d = wave_d + OUT_W'(amplitude);
                end else begin
                    wave_d = wave_d - OUT_W'(amplitude);
                end
            end
        end
    end

    // Registered mix output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wave_q <= '0;
        end else begin
            wave_q <= wave_d;
        end
    end

    assign voice_active = active_q;
    assign voice_stolen = stolen_q;
    assign wave_out     = wave_q;

endmodule

// File: tb/tb_poly_voice_controller.sv
// Scoreboard bench for poly_voice_controller: the driver queues expected values
// tagged with the clock edge they belong to; the monitor samples on each falling
// edge and compares every entry that is due.
module tb_poly_voice_controller;

    localparam int NV    = 4;
    localparam int OUT_W = 19;

    logic          clk;
    logic          reset;
    logic          ev_valid;
    logic          ev_ready;
    logic          ev_on;
    logic [6:0]    ev_key;
    logic [15:0]   ev_half_period;
    logic [15:0]   amplitude;
    logic [NV-1:0] voice_active;
    logic          voice_stolen;
    logic [OUT_W-1:0] wave_out;

    poly_voice_controller dut (
        .clk            (clk),
        .reset          (reset),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_on          (ev_on),
        .ev_key         (ev_key),
        .ev_half_period (ev_half_period),
        .amplitude      (amplitude),
        .voice_active   (voice_active),
        .voice_stolen   (voice_stolen),
        .wave_out       (wave_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: parallel queues, sig 0=wave_out 1=voice_active 2=voice_stolen 3=ev_ready
    int    q_due[$];
    int    q_sig[$];
    int    q_exp[$];
    string q_name[$];

    int checks = 0;
    int errors = 0;

    task automatic push(input int due, input string name, input int sig, input int val);
        q_due.push_back(due);
        q_sig.push_back(sig);
        q_exp.push_back(val);
        q_name.push_back(name);
    endtask

    // Monitor: compare all entries due at this falling edge
    initial begin
        int idx;
        int act;
        forever begin
            @(negedge clk);
            idx = 0;
            while (idx < q_due.size()) begin
                if (q_due[idx] <= cyc) begin
                    case (q_sig[idx])
                        0:       act = $signed(wave_out);
                        1:       act = int'(voice_active);
                        2:       act = int'(voice_stolen);
                        default: act = int'(ev_ready);
                    endcase
                    checks = checks + 1;
                    if (q_due[idx] != cyc) begin
                        errors = errors + 1;
                        $display("FAIL %s: check due at edge %0d reached late at edge %0d",
                                 q_name[idx], q_due[idx], cyc);
                    end else if (act != q_exp[idx]) begin
                        errors = errors + 1;
                        $display("FAIL %s: got %0d, want %0d (edge %0d)",
                                 q_name[idx], act, q_exp[idx], cyc);
                    end
                    q_due.delete(idx);
                    q_sig.delete(idx);
                    q_exp.delete(idx);
                    q_name.delete(idx);
                end else begin
                    idx = idx + 1;
                end
            end
        end
    end

    // Issue one event from a falling edge where ev_ready is 1; returns one cycle
    // after the processing edge, so ev_ready is 1 again.
    task automatic send(input logic on, input logic [6:0] key, input logic [15:0] hp,
                        input logic [3:0] exp_act, input logic exp_st);
        push(cyc + 1, $sformatf("ready_busy_%0h", key), 3, 0);
        push(cyc + 2, $sformatf("ready_back_%0h", key), 3, 1);
        push(cyc + 2, $sformatf("active_%0h", key), 1, int'(exp_act));
        push(cyc + 2, $sformatf("stolen_%0h", key), 2, int'(exp_st));
        if (exp_st) push(cyc + 3, $sformatf("stolen_clear_%0h", key), 2, 0);
        ev_valid       = 1'b1;
        ev_on          = on;
        ev_key         = key;
        ev_half_period = hp;
        @(negedge clk);
        ev_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b0;
        ev_valid       = 1'b0;
        ev_on          = 1'b0;
        ev_key         = '0;
        ev_half_period = '0;
        amplitude      = 16'd1000;

        // Outputs held at reset values
        push(2, "rst_wave", 0, 0);
        push(2, "rst_active", 1, 0);
        push(2, "rst_stolen", 2, 0);
        push(2, "rst_ready", 3, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single note, half period 3: +1000 x3, -1000 x3 from two cycles after accept
        push(cyc + 2, "wave_pre", 0, 0);
        send(1'b1, 7'h24, 16'd3, 4'b0001, 1'b0);
        for (int j = 0; j < 12; j++) begin
            push(cyc + 1 + j, $sformatf("wave_sq%0d", j), 0, ((j / 3) % 2 == 0) ? 1000 : -1000);
        end
        repeat (10) @(negedge clk);
        send(1'b0, 7'h24, 16'd0, 4'b0000, 1'b0);
        push(cyc + 1, "wave_off", 0, 0);

        // Fill all voices, then steal the oldest (voice 0)
        send(1'b1, 7'h10, 16'd100, 4'b0001, 1'b0);
        send(1'b1, 7'h11, 16'd100, 4'b0011, 1'b0);
        send(1'b1, 7'h12, 16'd100, 4'b0111, 1'b0);
        send(1'b1, 7'h13, 16'd100, 4'b1111, 1'b0);
        send(1'b1, 7'h14, 16'd100, 4'b1111, 1'b1);
        // Free voice 2 and reuse it, then the next steal takes voice 1 (key 0x11)
        send(1'b0, 7'h12, 16'd0, 4'b1011, 1'b0);
        send(1'b1, 7'h20, 16'd100, 4'b1111, 1'b0);
        send(1'b1, 7'h21, 16'd100, 4'b1111, 1'b1);
        send(1'b0, 7'h11, 16'd0, 4'b1111, 1'b0);
        send(1'b0, 7'h21, 16'd0, 4'b1101, 1'b0);
        push(cyc + 2, "wave_mix3", 0, 3000);
        push(cyc + 3, "wave_mix2", 0, 2000);
        send(1'b0, 7'h14, 16'd0, 4'b1100, 1'b0);

        // Retrigger key 0x13 (voice 3) with half period 2; voice 2 stays at +1000
        push(cyc + 3, "wave_rt0", 0, 2000);
        push(cyc + 4, "wave_rt1", 0, 2000);
        push(cyc + 5, "wave_rt2", 0, 0);
        push(cyc + 6, "wave_rt3", 0, 0);
        send(1'b1, 7'h13, 16'd2, 4'b1100, 1'b0);
        send(1'b0, 7'h7F, 16'd0, 4'b1100, 1'b0);

        // Back-to-back: ev_valid held 4 cycles, keys 0x30 and 0x32 are accepted
        push(cyc + 1, "b2b_ready0", 3, 0);
        push(cyc + 2, "b2b_ready1", 3, 1);
        push(cyc + 3, "b2b_ready2", 3, 0);
        push(cyc + 4, "b2b_ready3", 3, 1);
        push(cyc + 2, "b2b_active0", 1, 4'b1101);
        push(cyc + 4, "b2b_active1", 1, 4'b1111);
        push(cyc + 3, "b2b_wave0", 0, 3000);
        push(cyc + 4, "b2b_wave1", 0, 3000);
        push(cyc + 5, "b2b_wave2", 0, 2000);
        ev_valid       = 1'b1;
        ev_on          = 1'b1;
        ev_half_period = 16'd100;
        ev_key         = 7'h30;
        @(negedge clk);
        ev_key = 7'h31;
        @(negedge clk);
        ev_key = 7'h32;
        @(negedge clk);
        ev_key = 7'h33;
        @(negedge clk);
        ev_valid = 1'b0;
        send(1'b0, 7'h31, 16'd0, 4'b1111, 1'b0);
        send(1'b0, 7'h32, 16'd0, 4'b1101, 1'b0);

        // Reset asserted between edges must clear outputs before the next edge
        @(posedge clk);
        #2;
        reset = 1'b0;
        push(cyc, "arst_wave", 0, 0);
        push(cyc, "arst_active", 1, 0);
        push(cyc, "arst_stolen", 2, 0);
        push(cyc, "arst_ready", 3, 1);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        amplitude = 16'hFFFF;
        push(cyc + 1, "rel_ready", 3, 1);
        push(cyc + 1, "rel_active", 1, 0);
        push(cyc + 1, "rel_wave", 0, 0);
        @(negedge clk);

        // Full-scale mix: four voices at phase 1, amplitude 0xFFFF
        send(1'b1, 7'h40, 16'd1000, 4'b0001, 1'b0);
        send(1'b1, 7'h41, 16'd1000, 4'b0011, 1'b0);
        send(1'b1, 7'h42, 16'd1000, 4'b0111, 1'b0);
        push(cyc + 2, "wave_3fs", 0, 196605);
        send(1'b1, 7'h43, 16'd1000, 4'b1111, 1'b0);
        push(cyc + 1, "wave_full0", 0, 262140);
        push(cyc + 2, "wave_full1", 0, 262140);
        @(negedge clk);
        @(negedge clk);
        amplitude = 16'd2;
        push(cyc + 1, "wave_amp_step", 0, 8);
        @(negedge clk);

        // Reset mid-play at full scale
        @(posedge clk);
        #2;
        reset = 1'b0;
        push(cyc, "arst2_wave", 0, 0);
        push(cyc, "arst2_active", 1, 0);
        push(cyc, "arst2_ready", 3, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        push(cyc + 1, "rel2_ready", 3, 1);
        push(cyc + 1, "rel2_active", 1, 0);
        push(cyc + 1, "rel2_wave", 0, 0);
        repeat (3) @(negedge clk);

        if (q_due.size() != 0) begin
            $display("FAIL drain: got %0d pending checks, want 0", q_due.size());
            errors = errors + q_due.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
